// File: rtl/nlm_norm_divider_pkg.sv
// Shared definitions for the NLM normalising divider: default widths, FSM states,
// and a helper that sizes the iteration counter.
package nlm_norm_divider_pkg;

  localparam int NUM_WIDTH_DEF = 20;
  localparam int DEN_WIDTH_DEF = 12;
  localparam int QUO_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nlm_norm_divider_if.sv
// Valid/ready bundle between the adder-tree reduction, the normaliser and the
// denoised pixel output.
interface nlm_norm_divider_if
  import nlm_norm_divider_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF,
  parameter int DEN_WIDTH = DEN_WIDTH_DEF,
  parameter int QUO_WIDTH = QUO_WIDTH_DEF
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_WIDTH-1:0] in_num;
  logic [DEN_WIDTH-1:0] in_den;
  logic [QUO_WIDTH-1:0] in_fallback;
  logic                 out_valid;
  logic                 out_ready;
  logic [QUO_WIDTH-1:0] out_pix;
  logic                 out_dz;
  logic                 out_sat;

  modport master (
    output in_valid, in_num, in_den, in_fallback, out_ready,
    input  in_ready, out_valid, out_pix, out_dz, out_sat
  );

  modport slave (
    input  in_valid, in_num, in_den, in_fallback, out_ready,
    output in_ready, out_valid, out_pix, out_dz, out_sat
  );

endinterface

// File: rtl/nlm_div_step.sv
// One restoring-division step: shift the next numerator bit into the partial
// remainder and subtract the divisor when it fits.
module nlm_div_step #(
  parameter int DEN_WIDTH = 12
) (
  input  logic [DEN_WIDTH:0]   i_rem,
  input  logic                 i_num_bit,
  input  logic [DEN_WIDTH-1:0] i_den,
  output logic [DEN_WIDTH:0]   o_rem,
  output logic                 o_q_bit
);

  logic [DEN_WIDTH+1:0] w_shift;

  assign w_shift = {i_rem, i_num_bit};
  assign o_q_bit = (w_shift >= (DEN_WIDTH+2)'(i_den));
  // Incoming remainder is always < den, so the shifted value fits in DEN_WIDTH+1 bits.
  assign o_rem   = w_shift[DEN_WIDTH:0] - (o_q_bit ? {1'b0, i_den} : '0);

endmodule

// File: rtl/nlm_norm_divider.sv
// Sequential normaliser: weighted-pixel sum / weight sum, one quotient bit per
// cycle, round-half-up, saturate to the pixel range, fallback pixel on zero weight.
module nlm_norm_divider
  import nlm_norm_divider_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF,
  parameter int DEN_WIDTH = DEN_WIDTH_DEF,
  parameter int QUO_WIDTH = QUO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  nlm_norm_divider_if.slave bus
);

  localparam int CW = cnt_width(NUM_WIDTH);
  localparam logic [CW-1:0]        LAST_ITER = CW'(NUM_WIDTH - 1);
  localparam logic [QUO_WIDTH-1:0] PIX_MAX   = '1;

  state_e               r_state;
  state_e               w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [NUM_WIDTH-1:0] r_num;
  logic [NUM_WIDTH-2:0] r_quo;
  logic [DEN_WIDTH-1:0] r_den;
  logic [DEN_WIDTH:0]   r_rem;
  logic [QUO_WIDTH-1:0] r_pix;
  logic                 r_dz;
  logic                 r_sat;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_q_bit;
  logic [DEN_WIDTH:0]   w_rem;
  logic                 w_round_up;
  logic [NUM_WIDTH:0]   w_quo_rnd;
  logic                 w_sat;

  nlm_div_step #(.DEN_WIDTH(DEN_WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_num_bit (r_num[NUM_WIDTH-1]),
    .i_den     (r_den),
    .o_rem     (w_rem),
    .o_q_bit   (w_q_bit)
  );

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_cnt == LAST_ITER);

  // Rounding and saturation act on the final step's outputs so DONE is entered
  // on the same edge as the last quotient bit.
  assign w_round_up = ({w_rem, 1'b0} >= (DEN_WIDTH+2)'(r_den));
  assign w_quo_rnd  = {1'b0, r_quo, w_q_bit} + (NUM_WIDTH+1)'(w_round_up);
  assign w_sat      = |w_quo_rnd[NUM_WIDTH:QUO_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_state_next = (bus.in_den == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_num <= '0;
      r_quo <= '0;
      r_den <= '0;
      r_rem <= '0;
      r_pix <= '0;
      r_dz  <= 1'b0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_num <= bus.in_num;
      r_quo <= '0;
      r_den <= bus.in_den;
      r_rem <= '0;
      if (bus.in_den == '0) begin
        r_pix <= bus.in_fallback;
        r_dz  <= 1'b1;
        r_sat <= 1'b0;
      end
    end else if (r_state == ST_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_num <= {r_num[NUM_WIDTH-2:0], 1'b0};
      r_quo <= {r_quo[NUM_WIDTH-3:0], w_q_bit};
      r_rem <= w_rem;
      if (w_last) begin
        r_pix <= w_sat ? PIX_MAX : w_quo_rnd[QUO_WIDTH-1:0];
        r_dz  <= 1'b0;
        r_sat <= w_sat;
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_pix   = r_pix;
  assign bus.out_dz    = r_dz;
  assign bus.out_sat   = r_sat;

endmodule

// File: tb/tb_nlm_norm_divider.sv
// Directed and random transactions through nlm_norm_divider, each result checked
// against an arithmetic reference (divide, round half up, clamp, fallback).
module tb_nlm_norm_divider;

  localparam int NW = 20;
  localparam int DW = 12;
  localparam int QW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  nlm_norm_divider_if #(.NUM_WIDTH(NW), .DEN_WIDTH(DW), .QUO_WIDTH(QW)) bus ();

  nlm_norm_divider #(.NUM_WIDTH(NW), .DEN_WIDTH(DW), .QUO_WIDTH(QW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [NW-1:0] num, input logic [DW-1:0] den,
                                    input logic [QW-1:0] fb, output logic [QW-1:0] pix,
                                    output logic dz, output logic sat);
    longint q, r;
    if (den == 0) begin
      pix = fb; dz = 1'b1; sat = 1'b0;
    end else begin
      q = longint'(num) / longint'(den);
      r = longint'(num) % longint'(den);
      if (2 * r >= longint'(den)) q = q + 1;
      dz = 1'b0;
      if (q >= (longint'(1) << QW)) begin
        pix = '1; sat = 1'b1;
      end else begin
        pix = QW'(q); sat = 1'b0;
      end
    end
  endfunction

  // Latency counts edges from the accept cycle: accept edge is 1.
  task automatic txn(input logic [NW-1:0] num, input logic [DW-1:0] den,
                     input logic [QW-1:0] fb, input int hold);
    logic [QW-1:0] e_pix;
    logic          e_dz, e_sat;
    int            lat;
    ref_model(num, den, fb, e_pix, e_dz, e_sat);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_num      = num;
    bus.in_den      = den;
    bus.in_fallback = fb;
    for (int i = 0; i < 100 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_num   = 20'($urandom);
    bus.in_den   = 12'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), (den == 0) ? 32'd1 : 32'(NW + 1));
    chk("pix", 32'(bus.out_pix), 32'(e_pix));
    chk("dz", 32'(bus.out_dz), 32'(e_dz));
    chk("sat", 32'(bus.out_sat), 32'(e_sat));
    $display("txn num=%05h den=%03h fb=%03h -> pix=%03h dz=%0b sat=%0b lat=%0d hold=%0d",
             num, den, fb, bus.out_pix, bus.out_dz, bus.out_sat, lat, hold);
    // Stall: offer a competing input that must be ignored while the result is held.
    bus.in_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_pix", 32'(bus.out_pix), 32'(e_pix));
      chk("hold_flags", {30'd0, bus.out_dz, bus.out_sat}, {30'd0, e_dz, e_sat});
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("retire_valid", 32'(bus.out_valid), 32'd0);
    chk("retire_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [NW-1:0] r_num;
    logic [DW-1:0] r_den;
    bus.in_valid    = 1'b0;
    bus.in_num      = '0;
    bus.in_den      = '0;
    bus.in_fallback = '0;
    bus.out_ready   = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pix", 32'(bus.out_pix), 32'd0);
    chk("rst_flags", {30'd0, bus.out_dz, bus.out_sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(20'd100, 12'd7, 12'h000, 0);
    txn(20'd100, 12'd8, 12'h000, 0);
    txn(20'd99, 12'd8, 12'h000, 0);
    txn(20'd50, 12'd0, 12'h3A5, 0);
    txn(20'hFFFFF, 12'd1, 12'h000, 0);
    txn(20'd0, 12'd5, 12'h123, 0);
    txn(20'd12345, 12'd77, 12'h000, 5);
    txn(20'hFFFFF, 12'hFFF, 12'h000, 0);
    txn(20'd100, 12'd7, 12'h000, 0);

    // Reset during CALC iteration 10 aborts the transaction.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_num   = 20'd100;
    bus.in_den   = 12'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_pix", 32'(bus.out_pix), 32'd0);
    chk("midrst_flags", {30'd0, bus.out_dz, bus.out_sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(20'd100, 12'd8, 12'h000, 0);

    for (int k = 0; k < 30; k++) begin
      r_num = 20'($urandom_range(0, 20'hFFFFF));
      case ($urandom_range(0, 3))
        0:       r_den = 12'd0;
        1:       r_den = 12'($urandom_range(1, 15));
        default: r_den = 12'($urandom_range(1, 12'hFFF));
      endcase
      txn(r_num, r_den, 12'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
